// File: rtl/mips_arb_pkg.sv
// Shared types for the MIPS fetch/data memory arbiter.
// No logic; state encoding, owner encoding and default constants only.
// Used by the arbiter top and its testbench.
package mips_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;
    localparam int          CNT_W         = 8;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// master = arbiter view (owns the shared bus), slave = requesters + memory.
// Pure wiring; no latency, no flow control of its own.
interface mips_mem_arbiter_if;
    // instruction fetch port
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ready;
    // data (MEM stage) port
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    // shared memory bus
    logic        mem_req;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  mem_rdata, mem_ack,
        output inst_rdata, inst_ready,
        output data_rdata, data_ready,
        output mem_req, mem_wen, mem_addr, mem_wdata,
        output err
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output mem_rdata, mem_ack,
        input  inst_rdata, inst_ready,
        input  data_rdata, data_ready,
        input  mem_req, mem_wen, mem_addr, mem_wdata,
        input  err
    );

endinterface

// File: rtl/arb_wait_counter.sv
// Wait-state counter: counts memory wait cycles, flags count == limit.
// Latency: clear/increment take effect on the next rising edge; hit is combinational on count.
// No backpressure; caller stops enabling once hit is seen.
module arb_wait_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit,
    output logic         o_hit
);

    logic [W-1:0] r_cnt;

    // clear on a new grant, otherwise count enabled wait cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates fetch and data ports onto one variable-latency memory bus (ARB_FAIR_EN: round-robin).
// Latency: req in N -> mem_req N+1 -> ready N+2 at the earliest, +1 per memory wait cycle.
// Backpressure: requesters stall until their one-cycle ready pulse; at most one access per 3 cycles.
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DFLT
) (
    input  logic                clk,
    input  logic                rst,
    mips_mem_arbiter_if.master  bus
);

    localparam logic [CNT_W-1:0] LP_LIMIT = MAX_WAIT[CNT_W-1:0];

    arb_state_t  r_state;
    arb_state_t  w_next;
    owner_t      r_owner;
    owner_t      w_grant_own;
    logic [31:0] r_addr;
    logic [3:0]  r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_resp;
    logic        r_err;

    logic        w_grant;
    logic        w_in_wait;
    logic        w_ack;
    logic        w_hit;
    logic        w_timeout;
    logic        w_cnt_en;

    logic        w_mem_req;
    logic        w_inst_ready;
    logic        w_data_ready;
    logic        w_err;

    assign w_grant   = (r_state == IDLE) && (bus.inst_req || bus.data_req);
    assign w_in_wait = (r_state == I_WAIT) || (r_state == D_WAIT);
    // acks outside a wait state are stale and dropped here
    assign w_ack     = w_in_wait && bus.mem_ack;
    // an ack on the limit cycle wins over the timeout
    assign w_timeout = w_in_wait && !bus.mem_ack && w_hit;
    assign w_cnt_en  = w_in_wait && !bus.mem_ack && !w_hit;

`ifdef ARB_FAIR_EN
    owner_t r_last;

    // round-robin pick: on contention grant whoever did not win last time
    always_comb begin
        w_grant_own = OWN_INST;
        if (bus.data_req && bus.inst_req) begin
            w_grant_own = (r_last == OWN_DATA) ? OWN_INST : OWN_DATA;
        end else if (bus.data_req) begin
            w_grant_own = OWN_DATA;
        end
    end

    // remember the grantee of every grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= OWN_INST;
        end else if (w_grant) begin
            r_last <= w_grant_own;
        end
    end
`else
    // fixed priority: the MEM-stage access is older, so data wins
    always_comb begin
        w_grant_own = bus.data_req ? OWN_DATA : OWN_INST;
    end
`endif

    arb_wait_counter #(.W(CNT_W)) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_grant),
        .i_en    (w_cnt_en),
        .i_limit (LP_LIMIT),
        .o_hit   (w_hit)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state: grant only from IDLE, so RESP never re-grants a lingering request
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_next = (w_grant_own == OWN_DATA) ? D_WAIT : I_WAIT;
                end
            end
            I_WAIT, D_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs decoded from state and registers only
    always_comb begin
        w_mem_req    = w_in_wait;
        w_inst_ready = (r_state == RESP) && (r_owner == OWN_INST);
        w_data_ready = (r_state == RESP) && (r_owner == OWN_DATA);
        w_err        = (r_state == RESP) && r_err;
    end

    // latch the granted request, then capture the response or the timeout value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_INST;
            r_addr  <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
            r_resp  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_owner <= w_grant_own;
                r_err   <= 1'b0;
                if (w_grant_own == OWN_DATA) begin
                    r_addr  <= bus.data_addr;
                    r_wen   <= bus.data_wen;
                    r_wdata <= bus.data_wdata;
                end else begin
                    r_addr  <= bus.inst_addr;
                    r_wen   <= '0;
                    r_wdata <= '0;
                end
            end
            if (w_ack) begin
                r_resp <= bus.mem_rdata;
                r_err  <= 1'b0;
            end else if (w_timeout) begin
                r_resp <= ERR_DATA;
                r_err  <= 1'b1;
            end
        end
    end

    assign bus.mem_req    = w_mem_req;
    assign bus.mem_wen    = r_wen;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_wdata  = r_wdata;
    assign bus.inst_ready = w_inst_ready;
    assign bus.data_ready = w_data_ready;
    assign bus.inst_rdata = r_resp;
    assign bus.data_rdata = r_resp;
    assign bus.err        = w_err;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter (MAX_WAIT = 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected values are hand-computed per scenario.
module tb_mips_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mips_mem_arbiter_if bus();

    mips_mem_arbiter #(
        .MAX_WAIT (4),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wen   = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ack    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.inst_ready !== 1'b0) begin failures++; $display("FAIL rst_inst_ready got=%0h exp=0", bus.inst_ready); end
        checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL rst_data_ready got=%0h exp=0", bus.data_ready); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0h exp=0", bus.err); end
        checks++; if (bus.mem_wen !== 4'h0) begin failures++; $display("FAIL rst_mem_wen got=%0h exp=0", bus.mem_wen); end
        checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%0h exp=0", bus.mem_wdata); end
        checks++; if (bus.data_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%0h exp=0", bus.data_rdata); end
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
    endtask

    // fetch, memory acks in the first wait cycle
    task automatic test_fetch();
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'hBFC0_0000;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL fetch_mem_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL fetch_mem_addr got=%0h exp=bfc00000", bus.mem_addr); end
        checks++; if (bus.mem_wen !== 4'h0) begin failures++; $display("FAIL fetch_mem_wen got=%0h exp=0", bus.mem_wen); end
        checks++; if (bus.inst_ready !== 1'b0) begin failures++; $display("FAIL fetch_early_ready got=%0h exp=0", bus.inst_ready); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h2408_0001;
        tick();
        bus.mem_ack   = 1'b0;
        checks++; if (bus.inst_ready !== 1'b1) begin failures++; $display("FAIL fetch_inst_ready got=%0h exp=1", bus.inst_ready); end
        checks++; if (bus.inst_rdata !== 32'h2408_0001) begin failures++; $display("FAIL fetch_rdata got=%0h exp=24080001", bus.inst_rdata); end
        checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL fetch_data_ready got=%0h exp=0", bus.data_ready); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL fetch_err got=%0h exp=0", bus.err); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_resp_mem_req got=%0h exp=0", bus.mem_req); end
        bus.inst_req = 1'b0;
        tick();
        checks++; if (bus.inst_ready !== 1'b0) begin failures++; $display("FAIL fetch_single_pulse got=%0h exp=0", bus.inst_ready); end
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_idle_mem_req got=%0h exp=0", bus.mem_req); end
    endtask

    // store with ack in the third wait cycle; inputs change after grant to prove latching
    task automatic test_store_latency();
        int pulses;
        bus.data_req   = 1'b1;
        bus.data_wen   = 4'b1100;
        bus.data_addr  = 32'h0000_2000;
        bus.data_wdata = 32'hCAFE_F00D;
        tick();
        bus.data_wen   = 4'b0001;
        bus.data_addr  = 32'h0000_3000;
        bus.data_wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL store_mem_req[%0d] got=%0h exp=1", i, bus.mem_req); end
            checks++; if (bus.mem_wen !== 4'b1100) begin failures++; $display("FAIL store_mem_wen[%0d] got=%0h exp=c", i, bus.mem_wen); end
            checks++; if (bus.mem_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL store_mem_wdata[%0d] got=%0h exp=cafef00d", i, bus.mem_wdata); end
            checks++; if (bus.mem_addr !== 32'h0000_2000) begin failures++; $display("FAIL store_mem_addr[%0d] got=%0h exp=2000", i, bus.mem_addr); end
            checks++; if (bus.data_ready !== 1'b0) begin failures++; $display("FAIL store_early_ready[%0d] got=%0h exp=0", i, bus.data_ready); end
            if (i == 2) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'h1111_2222;
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL store_data_ready got=%0h exp=1", bus.data_ready); end
        checks++; if (bus.data_rdata !== 32'h1111_2222) begin failures++; $display("FAIL store_rdata got=%0h exp=11112222", bus.data_rdata); end
        bus.data_req = 1'b0;
        bus.data_wen = 4'h0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.data_ready === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL store_extra_pulses got=%0d exp=0", pulses); end
    endtask

    // simultaneous requests; order depends on arbitration mode
    task automatic test_both();
        logic        first_data;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [3:0]  w1;
        logic [3:0]  w2;
`ifdef ARB_FAIR_EN
        first_data = 1'b0;  // previous grant went to data
`else
        first_data = 1'b1;
`endif
        a1 = first_data ? 32'h0000_0010 : 32'hBFC0_0004;
        a2 = first_data ? 32'hBFC0_0004 : 32'h0000_0010;
        w1 = first_data ? 4'b0011 : 4'b0000;
        w2 = first_data ? 4'b0000 : 4'b0011;
        bus.inst_req   = 1'b1;
        bus.inst_addr  = 32'hBFC0_0004;
        bus.data_req   = 1'b1;
        bus.data_wen   = 4'b0011;
        bus.data_addr  = 32'h0000_0010;
        bus.data_wdata = 32'h55AA_55AA;
        tick();
        checks++; if (bus.mem_addr !== a1) begin failures++; $display("FAIL both_first_addr got=%0h exp=%0h", bus.mem_addr, a1); end
        checks++; if (bus.mem_wen !== w1) begin failures++; $display("FAIL both_first_wen got=%0h exp=%0h", bus.mem_wen, w1); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA0A0_0001;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.data_ready !== first_data) begin failures++; $display("FAIL both_first_data_ready got=%0h exp=%0h", bus.data_ready, first_data); end
        checks++; if (bus.inst_ready !== !first_data) begin failures++; $display("FAIL both_first_inst_ready got=%0h exp=%0h", bus.inst_ready, !first_data); end
        if (first_data) bus.data_req = 1'b0; else bus.inst_req = 1'b0;
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL both_idle_gap got=%0h exp=0", bus.mem_req); end
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL both_second_mem_req got=%0h exp=1", bus.mem_req); end
        checks++; if (bus.mem_addr !== a2) begin failures++; $display("FAIL both_second_addr got=%0h exp=%0h", bus.mem_addr, a2); end
        checks++; if (bus.mem_wen !== w2) begin failures++; $display("FAIL both_second_wen got=%0h exp=%0h", bus.mem_wen, w2); end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hA0A0_0002;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.inst_ready !== first_data) begin failures++; $display("FAIL both_second_inst_ready got=%0h exp=%0h", bus.inst_ready, first_data); end
        checks++; if (bus.data_ready !== !first_data) begin failures++; $display("FAIL both_second_data_ready got=%0h exp=%0h", bus.data_ready, !first_data); end
        checks++; if (bus.inst_rdata !== 32'hA0A0_0002) begin failures++; $display("FAIL both_second_rdata got=%0h exp=a0a00002", bus.inst_rdata); end
        idle_inputs();
        tick();
    endtask

    // no ack: wait counts 0..4, timeout after the fifth wait cycle
    task automatic test_timeout();
        bus.data_req  = 1'b1;
        bus.data_wen  = 4'h0;
        bus.data_addr = 32'h0000_0040;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.data_ready !== 1'b0) begin failures++; $display("FAIL tmo_wait[%0d] got=%0h%0h exp=10", i, bus.mem_req, bus.data_ready); end
            tick();
        end
        checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL tmo_data_ready got=%0h exp=1", bus.data_ready); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%0h exp=1", bus.err); end
        checks++; if (bus.data_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL tmo_rdata got=%0h exp=deadbeef", bus.data_rdata); end
        bus.data_req = 1'b0;
        tick();
        checks++; if (bus.err !== 1'b0 || bus.data_ready !== 1'b0) begin failures++; $display("FAIL tmo_pulse_end got=%0h%0h exp=00", bus.err, bus.data_ready); end
    endtask

    // ack arrives on the cycle the counter equals MAX_WAIT
    task automatic test_ack_at_limit();
        bus.data_req  = 1'b1;
        bus.data_wen  = 4'h0;
        bus.data_addr = 32'h0000_0044;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'h1234_5678;
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        checks++; if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL lim_data_ready got=%0h exp=1", bus.data_ready); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL lim_err got=%0h exp=0", bus.err); end
        checks++; if (bus.data_rdata !== 32'h1234_5678) begin failures++; $display("FAIL lim_rdata got=%0h exp=12345678", bus.data_rdata); end
        bus.data_req = 1'b0;
        tick();
    endtask

    // reset during D_WAIT, then a stale ack must be ignored
    task automatic test_reset_mid();
        int pulses;
        bus.data_req   = 1'b1;
        bus.data_wen   = 4'b1111;
        bus.data_addr  = 32'h0000_0080;
        bus.data_wdata = 32'h0000_0001;
        tick();
        checks++; if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rmid_pre_mem_req got=%0h exp=1", bus.mem_req); end
        rst = 1'b0;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rmid_mem_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wen !== 4'h0 || bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rmid_bus got=%0h/%0h/%0h exp=0/0/0", bus.mem_addr, bus.mem_wen, bus.mem_wdata); end
        idle_inputs();
        #2 rst = 1'b1;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0000_0099;
        tick();
        bus.mem_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.data_ready === 1'b1 || bus.inst_ready === 1'b1 || bus.err === 1'b1) pulses++;
            checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rmid_idle[%0d] got=%0h exp=0", i, bus.mem_req); end
            tick();
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL rmid_pulses got=%0d exp=0", pulses); end
        checks++; if (bus.data_rdata !== 32'h0) begin failures++; $display("FAIL rmid_stale_rdata got=%0h exp=0", bus.data_rdata); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fetch();
        test_store_latency();
        test_both();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Single-port memory arbiter between the MIPS pipeline's instruction-fetch port and its data (MEM-stage) port. It feeds one shared, variable-latency SRAM-style bus. Each request is granted, latched and held on the bus until the memory acknowledges or a wait timeout fires, then the result returns to the winning requester with a one-cycle ready pulse. Requesters stall on `!ready`; the arbiter is the only master of the shared bus.

## Interface
Parameters:
- `MAX_WAIT`, 255 — cycles in a wait state before timeout; range 1..255.
- `ERR_DATA`, 32'hDEAD_BEEF — read data returned on timeout.

Ports:
- `clk` in 1 — sole clock; all state on rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `inst_req` in 1 — fetch request; held until `inst_ready`.
- `inst_addr` in 32 — fetch address, sampled at grant.
- `inst_rdata` out 32 — fetched word, valid while `inst_ready`.
- `inst_ready` out 1 — one-cycle completion pulse.
- `data_req` in 1 — data request; held until `data_ready`.
- `data_wen` in 4 — byte write strobes; 0 means read.
- `data_addr` in 32 — data address.
- `data_wdata` in 32 — store data.
- `data_rdata` out 32 — load data, valid while `data_ready`.
- `data_ready` out 1 — one-cycle completion pulse.
- `mem_req` out 1 — bus request, high throughout a wait state.
- `mem_wen` out 4 — latched byte strobes; forced 0 for fetches.
- `mem_addr` out 32 — latched address.
- `mem_wdata` out 32 — latched store data.
- `mem_rdata` in 32 — memory read data, valid with `mem_ack`.
- `mem_ack` in 1 — one-cycle completion from memory.
- `err` out 1 — one-cycle pulse, coincident with the ready pulse of a timed-out access.

## Operation
- States: `IDLE`, `I_WAIT`, `D_WAIT`, `RESP`.
- `IDLE`:
  - Grant when any request is high: latch address, strobes and write data; clear the wait counter.
  - Go to `I_WAIT` or `D_WAIT`. Record the grantee in `owner`.
  - No request: stay in `IDLE`.
- Arbitration (default): `data_req` beats `inst_req`. The MEM-stage access is older.
- `I_WAIT` / `D_WAIT`:
  - `mem_req` = 1 and bus outputs stay constant.
  - On `mem_ack`: capture `mem_rdata` into the response register and go to `RESP`.
  - Otherwise increment the counter. When the counter reaches `MAX_WAIT`, load `ERR_DATA`, set the error flag and go to `RESP`.
- `RESP`:
  - Assert `owner`'s ready (and `err` if flagged) for exactly one cycle, then return to `IDLE`.
  - No grant is made in `RESP`, so a requester still holding `req` in its ready cycle is never re-granted.
- For writes, the ready pulse still occurs; `data_rdata` carries whatever the memory returned with the ack.
- `mem_ack` while in `IDLE` or `RESP` is ignored. Such an ack is a stale response, e.g. after a reset.
- Outputs `inst_rdata` and `data_rdata` are driven from the same response register. Each is meaningful only with its own ready.

## Timing
- Reset values:
  - State `IDLE`, counter 0, `owner` = inst.
  - `mem_req`, `inst_ready`, `data_ready`, `err` = 0.
  - `mem_wen` = 0, `mem_addr` = 0, `mem_wdata` = 0, response register 0.
- Latency: request seen in cycle N → `mem_req` in N+1 → ack earliest in N+1 → ready in N+2. Each memory wait cycle adds 1.
- Back-to-back: the next grant is earliest one cycle after `RESP`, so throughput is at most one access per 3 cycles.
- `mem_ack` in the same cycle the counter hits `MAX_WAIT`: the ack wins and `err` stays low.
- Reset asserted mid-access: immediate return to reset values; the in-flight access is abandoned with no ready pulse.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.

## Configuration
- `ARB_FAIR_EN` defined:
  - Round-robin arbitration. A `last` register (reset to inst) records the grantee of each grant.
  - When both requests are high in `IDLE`, grant the one that is not `last`.
  - A single request is granted regardless of `last`.
- `ARB_FAIR_EN` undefined:
  - Fixed data-over-inst priority. No `last` register exists.

## Structure
- Package `mips_arb_pkg`: state enum (`IDLE`, `I_WAIT`, `D_WAIT`, `RESP`), owner encoding (`OWN_INST`/`OWN_DATA`), default `ERR_DATA` constant.
- Sub-module `arb_wait_counter`: 8-bit counter with clear, enable and `hit` (count == limit) output, instantiated once.

## Test plan
- Fetch only, memory acks 1 cycle after `mem_req`: `inst_req` at cycle 0 with addr 0xBFC0_0000 → `mem_req` cycle 1, `mem_addr` 0xBFC0_0000, `mem_wen` 0; `inst_ready` cycle 2 with the rdata the memory supplied.
- Both requesting at cycle 0, default build: store, `data_wen` 4'b0011, addr 0x10 → data granted first; fetch granted in the `IDLE` cycle after `data_ready`. With `ARB_FAIR_EN` and `last` = data, the fetch is granted first.
- Store with 3-cycle memory latency: `mem_wdata` and `mem_wen` hold constant across all wait cycles; exactly one `data_ready` pulse.
- No ack, `MAX_WAIT` = 4 → `data_ready` and `err` pulse together with `data_rdata` = 0xDEAD_BEEF; ack on the exact `MAX_WAIT` cycle → `err` = 0, real data returned.
- `rst` low during `D_WAIT`, then stale `mem_ack` after release → all outputs at reset values, no ready pulse, state stays `IDLE`.
